alu_rr_sequencer: RTL and testbench

- Round-robin controller that shares one combinational WIDTH-bit ripple ALU between two requesters.
- Decodes a 3-bit opcode into the ALU's ainvert/bnegate/op controls and registers the ALU outputs.
- Returns one tagged response per accepted request, with valid/ready on both sides.
- Sequences a multi-cycle unsigned MUL as a shift-add loop that reuses the ALU's ADD path; the ALU is external, and this block only drives and samples its ports.

---
 rtl/alu_rr_sequencer_pkg.sv | 48 ++++
 rtl/alu_rr_sequencer_if.sv | 57 +++++
 rtl/alu_rr_sequencer_rr_arb2.sv | 35 +++
 rtl/alu_rr_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rr_sequencer_pkg.sv
// Shared opcode, ALU-control and FSM encodings for the round-robin ALU sequencer.
// The decode function maps a request opcode onto the ripple ALU control triple.
package alu_seq_pkg;

   localparam logic [2:0] OPC_AND  = 3'd0;
   localparam logic [2:0] OPC_OR   = 3'd1;
   localparam logic [2:0] OPC_ADD  = 3'd2;
   localparam logic [2:0] OPC_SUB  = 3'd3;
   localparam logic [2:0] OPC_SLT  = 3'd4;
   localparam logic [2:0] OPC_NOR  = 3'd5;
   localparam logic [2:0] OPC_MUL  = 3'd6;
   localparam logic [2:0] OPC_RSVD = 3'd7;

   localparam logic [1:0] ALUOP_AND  = 2'd0;
   localparam logic [1:0] ALUOP_OR   = 2'd1;
   localparam logic [1:0] ALUOP_ADD  = 2'd2;
   localparam logic [1:0] ALUOP_LESS = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   typedef struct packed {
      logic       ainvert;
      logic       bnegate;
      logic [1:0] op;
   } alu_ctl_t;

   // MUL decodes to plain ADD because each shift-add step uses the adder.
   function automatic alu_ctl_t decode_opc(input logic [2:0] opc);
      alu_ctl_t c;
      case (opc)
         OPC_AND: c = {1'b0, 1'b0, ALUOP_AND};
         OPC_OR:  c = {1'b0, 1'b0, ALUOP_OR};
         OPC_ADD: c = {1'b0, 1'b0, ALUOP_ADD};
         OPC_SUB: c = {1'b0, 1'b1, ALUOP_ADD};
         OPC_SLT: c = {1'b0, 1'b1, ALUOP_LESS};
         OPC_NOR: c = {1'b1, 1'b1, ALUOP_AND};
         OPC_MUL: c = {1'b0, 1'b0, ALUOP_ADD};
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Bundles the two request ports, the response port and the external ALU port.
// master is the sequencer side, slave is the requesters/consumer/ALU side.
interface alu_rr_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_opcode;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_opcode;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_overflow;
   logic             rsp_zero;
   logic             rsp_err;

   logic [WIDTH-1:0] alu_in1;
   logic [WIDTH-1:0] alu_in2;
   logic             alu_ainvert;
   logic             alu_bnegate;
   logic [1:0]       alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_overflow;
   logic             alu_zero;

   modport master (
      input  req0_valid, req0_opcode, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_opcode, req1_a, req1_b,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_err,
      input  rsp_ready,
      output alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op,
      input  alu_result, alu_overflow, alu_zero
   );

   modport slave (
      output req0_valid, req0_opcode, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_opcode, req1_a, req1_b,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_err,
      output rsp_ready,
      input  alu_in1, alu_in2, alu_ainvert, alu_bnegate, alu_op,
      output alu_result, alu_overflow, alu_zero
   );

endinterface

// File: rtl/alu_rr_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last time wins.
// ready is combinational from enable, valid and the last_grant register.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] valid,
   output logic [1:0] ready,
   output logic       grant_id
);

   logic last_grant;

   always_comb begin
      grant_id = 1'b0;
      case (valid)
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
      ready = 2'b00;
      if (enable && (valid != 2'b00)) begin
         ready = grant_id ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (ready != 2'b00) begin
         last_grant <= grant_id;
      end
   end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one external ripple ALU between two requesters, one request in flight.
// Single-cycle ops go IDLE->EXEC->RESP; MUL runs WIDTH shift-add steps on the ALU adder.
module alu_rr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   alu_rr_sequencer_if.master bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic             grant_id;
   logic             accept;

   logic [2:0]       sel_opcode;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   logic [2:0]       lat_opcode;
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_nxt;

   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_overflow;
   logic             rsp_zero;
   logic             rsp_err;

   logic [WIDTH-1:0] drv_in1;
   logic [WIDTH-1:0] drv_in2;
   alu_ctl_t         drv_ctl;
   logic             drv_rsp_valid;

   assign req_valid = {bus.req1_valid, bus.req0_valid};

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .enable   (state == ST_IDLE),
      .valid    (req_valid),
      .ready    (req_ready),
      .grant_id (grant_id)
   );

   assign accept         = |req_ready;
   assign bus.req0_ready = req_ready[0];
   assign bus.req1_ready = req_ready[1];

   assign sel_opcode = grant_id ? bus.req1_opcode : bus.req0_opcode;
   assign sel_a      = grant_id ? bus.req1_a      : bus.req0_a;
   assign sel_b      = grant_id ? bus.req1_b      : bus.req0_b;

   assign acc_nxt = mplr[0] ? bus.alu_result : acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (sel_opcode)
                  OPC_MUL:  state_nxt = ST_MUL;
                  OPC_RSVD: state_nxt = ST_RESP;
                  default:  state_nxt = ST_EXEC;
               endcase
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_MUL: begin
            if (cnt == CNT_LAST) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      drv_in1       = '0;
      drv_in2       = '0;
      drv_ctl       = '0;
      drv_rsp_valid = 1'b0;
      case (state)
         ST_EXEC: begin
            drv_in1 = lat_a;
            drv_in2 = lat_b;
            drv_ctl = decode_opc(lat_opcode);
         end
         ST_MUL: begin
            drv_in1 = acc;
            drv_in2 = mcand;
            drv_ctl = decode_opc(OPC_MUL);
         end
         ST_RESP: drv_rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.alu_in1      = drv_in1;
   assign bus.alu_in2      = drv_in2;
   assign bus.alu_ainvert  = drv_ctl.ainvert;
   assign bus.alu_bnegate  = drv_ctl.bnegate;
   assign bus.alu_op       = drv_ctl.op;
   assign bus.rsp_valid    = drv_rsp_valid;
   assign bus.rsp_id       = rsp_id;
   assign bus.rsp_result   = rsp_result;
   assign bus.rsp_overflow = rsp_overflow;
   assign bus.rsp_zero     = rsp_zero;
   assign bus.rsp_err      = rsp_err;

   // Response fields only move on accept/EXEC/MUL, so they are frozen throughout RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_opcode   <= '0;
         lat_a        <= '0;
         lat_b        <= '0;
         acc          <= '0;
         mcand        <= '0;
         mplr         <= '0;
         cnt          <= '0;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b1;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_opcode   <= sel_opcode;
                  lat_a        <= sel_a;
                  lat_b        <= sel_b;
                  acc          <= '0;
                  mcand        <= sel_a;
                  mplr         <= sel_b;
                  cnt          <= '0;
                  rsp_id       <= grant_id;
                  rsp_err      <= (sel_opcode == OPC_RSVD);
                  if (sel_opcode == OPC_RSVD) begin
                     rsp_result   <= '0;
                     rsp_overflow <= 1'b0;
                     rsp_zero     <= 1'b1;
                  end
               end
            end
            ST_EXEC: begin
               rsp_result   <= bus.alu_result;
               rsp_zero     <= bus.alu_zero;
               rsp_overflow <= bus.alu_overflow &&
                               ((lat_opcode == OPC_ADD) || (lat_opcode == OPC_SUB));
            end
            ST_MUL: begin
               acc   <= acc_nxt;
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  rsp_result   <= acc_nxt;
                  rsp_zero     <= (acc_nxt == '0);
                  rsp_overflow <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer at WIDTH=8 with a behavioural ripple ALU attached.
// Expected responses are queued on accept and compared when the consumer takes them.
module tb_alu_rr_sequencer;
   import alu_seq_pkg::*;

   localparam int W = 8;

   typedef struct {
      logic         id;
      logic [W-1:0] res;
      logic         ovf;
      logic         zero;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   alu_rr_sequencer_if #(.WIDTH(W)) bus ();

   alu_rr_sequencer #(.WIDTH(W), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural ripple ALU: a/b optionally inverted, carry-in = bnegate, SLT from sign^overflow.
   logic [W-1:0] am, bm, sm, rm;
   logic         ovf_m;
   always_comb begin
      am    = bus.alu_ainvert ? ~bus.alu_in1 : bus.alu_in1;
      bm    = bus.alu_bnegate ? ~bus.alu_in2 : bus.alu_in2;
      sm    = am + bm + W'(bus.alu_bnegate);
      ovf_m = (am[W-1] == bm[W-1]) && (sm[W-1] != am[W-1]);
      case (bus.alu_op)
         2'd0:    rm = am & bm;
         2'd1:    rm = am | bm;
         2'd2:    rm = sm;
         default: rm = W'(sm[W-1] ^ ovf_m);
      endcase
      bus.alu_result   = rm;
      bus.alu_overflow = ovf_m;
      bus.alu_zero     = (rm == '0);
   end

   function automatic exp_t model(input logic id, input logic [2:0] opc,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      logic [15:0] p;
      e.id  = id;
      e.res = '0;
      e.ovf = 1'b0;
      e.err = 1'b0;
      p     = '0;
      case (opc)
         OPC_AND: e.res = a & b;
         OPC_OR:  e.res = a | b;
         OPC_ADD: begin
            e.res = a + b;
            e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         OPC_SUB: begin
            e.res = a - b;
            e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         OPC_SLT: e.res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
         OPC_NOR: e.res = ~(a | b);
         OPC_MUL: begin
            p     = {8'b0, a} * {8'b0, b};
            e.res = p[7:0];
         end
         default: e.err = 1'b1;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int who, input logic v, input logic [2:0] opc,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      if (who == 0) begin
         bus.req0_valid = v; bus.req0_opcode = opc; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_opcode = opc; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   // Returns just after the accept edge; the expectation is queued from the accepted operands.
   task automatic wait_accept(output int got);
      got = -1;
      for (int n = 0; n < 50 && got < 0; n++) begin
         @(negedge clk);
         if (bus.req0_valid && bus.req0_ready) begin
            got = 0;
            q.push_back(model(1'b0, bus.req0_opcode, bus.req0_a, bus.req0_b));
         end else if (bus.req1_valid && bus.req1_ready) begin
            got = 1;
            q.push_back(model(1'b1, bus.req1_opcode, bus.req1_a, bus.req1_b));
         end
      end
      if (got < 0) begin
         chk("accept_timeout", 32'd1, 32'd0);
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic meas_lat(input string tag, input int exp_lat);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid && n < 40);
      chk(tag, 32'(n), 32'(exp_lat));
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 32'(q.size()), 32'd0);
      #1;
   endtask

   task automatic issue(input int who, input logic [2:0] opc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input string tag);
      int got;
      @(posedge clk);
      #1;
      set_req(who, 1'b1, opc, a, b);
      wait_accept(got);
      chk({tag, "_grant"}, 32'(got), 32'(who));
      set_req(who, 1'b0, 3'd0, '0, '0);
      meas_lat({tag, "_lat"}, exp_lat);
      drain();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               mon_e = q.pop_front();
               chk("rsp_id",       32'(bus.rsp_id),       32'(mon_e.id));
               chk("rsp_result",   32'(bus.rsp_result),   32'(mon_e.res));
               chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(mon_e.ovf));
               chk("rsp_zero",     32'(bus.rsp_zero),     32'(mon_e.zero));
               chk("rsp_err",      32'(bus.rsp_err),      32'(mon_e.err));
            end
         end
      end
   end

   initial begin
      int got;
      set_req(0, 1'b0, 3'd0, '0, '0);
      set_req(1, 1'b0, 3'd0, '0, '0);
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
      chk("rst_rsp_zero",   32'(bus.rsp_zero),   32'd1);
      chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
      chk("rst_rsp_id",     32'(bus.rsp_id),     32'd0);
      chk("rst_rsp_err",    32'(bus.rsp_err),    32'd0);
      chk("rst_alu_in1",    32'(bus.alu_in1),    32'd0);
      chk("rst_alu_op",     32'(bus.alu_op),     32'd0);

      issue(0, OPC_ADD, 8'h7F, 8'h01, 2, "add");
      issue(1, OPC_SUB, 8'h05, 8'h05, 2, "sub");
      issue(1, OPC_SLT, 8'hFE, 8'h01, 2, "slt");
      issue(0, OPC_AND, 8'hC3, 8'hA5, 2, "and");
      issue(1, OPC_OR,  8'h30, 8'h0C, 2, "or");

      // Both requesters hold NOR continuously; grants must alternate starting at 0.
      @(posedge clk);
      #1;
      set_req(0, 1'b1, OPC_NOR, 8'h0F, 8'hF0);
      set_req(1, 1'b1, OPC_NOR, 8'h0F, 8'hF0);
      for (int k = 0; k < 4; k++) begin
         wait_accept(got);
         chk("rr_grant", 32'(got), 32'(k % 2));
      end
      set_req(0, 1'b0, 3'd0, '0, '0);
      set_req(1, 1'b0, 3'd0, '0, '0);
      drain();

      issue(0, OPC_MUL, 8'd13, 8'd11, 9, "mul13x11");
      issue(0, OPC_MUL, 8'h10, 8'h10, 9, "mul16x16");
      issue(1, OPC_MUL, 8'hFF, 8'hFF, 9, "mulffxff");

      // Reserved opcode, then stall the consumer while both requesters wait.
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      set_req(1, 1'b1, OPC_RSVD, 8'hAA, 8'h55);
      wait_accept(got);
      chk("rsvd_grant", 32'(got), 32'd1);
      set_req(1, 1'b0, 3'd0, '0, '0);
      meas_lat("rsvd_lat", 1);
      @(posedge clk);
      #1;
      set_req(0, 1'b1, OPC_ADD, 8'h01, 8'h01);
      set_req(1, 1'b1, OPC_ADD, 8'h02, 8'h02);
      repeat (5) begin
         @(negedge clk);
         chk("hold_ready0",  32'(bus.req0_ready), 32'd0);
         chk("hold_ready1",  32'(bus.req1_ready), 32'd0);
         chk("hold_valid",   32'(bus.rsp_valid),  32'd1);
         chk("hold_err",     32'(bus.rsp_err),    32'd1);
         chk("hold_result",  32'(bus.rsp_result), 32'd0);
         chk("hold_id",      32'(bus.rsp_id),     32'd1);
         chk("hold_alu_in1", 32'(bus.alu_in1),    32'd0);
      end
      @(posedge clk);
      #1;
      set_req(0, 1'b0, 3'd0, '0, '0);
      set_req(1, 1'b0, 3'd0, '0, '0);
      bus.rsp_ready = 1'b1;
      drain();

      // Reset during MUL iteration 4: no response, req0 wins the following tie.
      @(posedge clk);
      #1;
      set_req(0, 1'b1, OPC_MUL, 8'd3, 8'd5);
      wait_accept(got);
      set_req(0, 1'b0, 3'd0, '0, '0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      @(negedge clk);
      chk("mrst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
      chk("mrst_alu_in1",    32'(bus.alu_in1),    32'd0);
      chk("mrst_alu_in2",    32'(bus.alu_in2),    32'd0);
      chk("mrst_alu_op",     32'(bus.alu_op),     32'd0);
      chk("mrst_rsp_zero",   32'(bus.rsp_zero),   32'd1);
      chk("mrst_rsp_result", 32'(bus.rsp_result), 32'd0);
      @(posedge clk);
      #1;
      set_req(0, 1'b1, OPC_ADD, 8'h01, 8'h02);
      set_req(1, 1'b1, OPC_AND, 8'hFF, 8'h0F);
      wait_accept(got);
      chk("mrst_grant", 32'(got), 32'd0);
      set_req(0, 1'b0, 3'd0, '0, '0);
      set_req(1, 1'b0, 3'd0, '0, '0);
      meas_lat("mrst_lat", 2);
      drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
